fir_filter_top: RTL and testbench

Memory-resident 4-tap FIR filter engine with a selectable non-pipelined or pipelined datapath. On `start` it reads a fixed block of 8-bit signed samples from an internal dual-port RAM. It filters them and writes results back to the same RAM. It counts busy cycles so the two datapaths can be compared for throughput; both must produce bit-identical outputs.

---
 rtl/fir_filter_top.sv | 214 +++++++++++++++++++++
 tb/tb_fir_filter_top.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_top.sv
// fir_filter_top: memory-resident 4-tap FIR, y[n] = sat8((x[n]+2x[n-1]+2x[n-2]+x[n-3]) >>> 3)
// Latency: 6 cycles/sample non-pipelined, N+2 cycles per run pipelined; done rises the cycle after the last write
// Backpressure: none; start edges are ignored while busy, port A is left idle (we_a=0) outside a run
// Ports: clk, rst (async, active-high), start (edge-triggered), sel_pipelined (sampled at the start edge),
//        done (held until the next accepted start), cycle_count (low 3 bits of the busy-cycle counter)
module fir_filter_top #(
    parameter int IN_BASE   = 0,
    parameter int OUT_BASE  = 32,
    parameter int N_SAMPLES = 20,
    parameter int MEM_DEPTH = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel_pipelined,
    output logic       done,
    output logic [2:0] cycle_count
);
    localparam int AW = 10;
    localparam int IW = 16;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_WR, S_PIPE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic [IW-1:0]         n_q, n_d;
    logic [1:0]            k_q, k_d;
    logic [1:0]            pw_q, pw_d;      // tap weight of the sample arriving on port B this cycle (0 = none)
    logic signed [11:0]    acc_q, acc_d;
    logic [7:0]            d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [7:0]            y_q, y_d;
    logic                  done_q, done_d;
    logic [31:0]           cycle_counter, cycle_counter_d;

    logic [AW-1:0]         addr_a, addr_b;
    logic                  we_a, re_b;
    logic [7:0]            data_in_a, rdata_b;
    logic                  start_edge;
    logic signed [11:0]    contrib, pipe_sum;

    function automatic logic signed [11:0] sx(input logic [7:0] v);
        return {{4{v[7]}}, v};
    endfunction

    function automatic logic [7:0] sat8(input logic signed [11:0] a);
        logic signed [11:0] s;
        s = a >>> 3;
        if (s > 12'sd127)       return 8'h7f;
        else if (s < -12'sd128) return 8'h80;
        else                    return s[7:0];
    endfunction

    assign start_d    = start;
    assign start_edge = start & ~start_q;
    assign contrib    = (pw_q == 2'd1) ? sx(rdata_b) :
                        (pw_q == 2'd2) ? (sx(rdata_b) <<< 1) : 12'sd0;
    // rdata_b holds x[i-1] in pipelined cycle i; the delay line still holds the older taps
    assign pipe_sum   = sx(rdata_b) + (sx(d1_q) <<< 1) + (sx(d2_q) <<< 1) + sx(d3_q);

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        k_d             = k_q;
        pw_d            = 2'd0;
        acc_d           = acc_q;
        d1_d            = d1_q;
        d2_d            = d2_q;
        d3_d            = d3_q;
        y_d             = y_q;
        done_d          = done_q;
        cycle_counter_d = cycle_counter;
        re_b            = 1'b0;
        addr_b          = '0;
        we_a            = 1'b0;
        addr_a          = '0;
        data_in_a       = '0;

        if (state_q inside {S_RD, S_ACC, S_WR, S_PIPE})
            cycle_counter_d = cycle_counter + 32'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    done_d          = 1'b0;
                    cycle_counter_d = '0;
                    n_d             = '0;
                    k_d             = '0;
                    d1_d            = '0;
                    d2_d            = '0;
                    d3_d            = '0;
                    state_d         = sel_pipelined ? S_PIPE : S_RD;
                end
            end
            S_RD: begin
                // read x[n-k]; its data arrives next cycle and is weighted then
                acc_d = (k_q == 2'd0) ? 12'sd0 : acc_q + contrib;
                if (n_q >= IW'(k_q)) begin
                    re_b   = 1'b1;
                    addr_b = AW'(IN_BASE) + n_q[AW-1:0] - AW'(k_q);
                    pw_d   = (k_q == 2'd0 || k_q == 2'd3) ? 2'd1 : 2'd2;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_ACC;
            end
            S_ACC: begin
                acc_d   = acc_q + contrib;
                state_d = S_WR;
            end
            S_WR: begin
                we_a      = 1'b1;
                addr_a    = AW'(OUT_BASE) + n_q[AW-1:0];
                data_in_a = sat8(acc_q);
                if (n_q == IW'(N_SAMPLES - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_PIPE: begin
                // n_q is the pipeline cycle: read x[n], filter x[n-1], write y[n-2]
                if (n_q < IW'(N_SAMPLES)) begin
                    re_b   = 1'b1;
                    addr_b = AW'(IN_BASE) + n_q[AW-1:0];
                end
                if (n_q >= IW'(1) && n_q <= IW'(N_SAMPLES)) begin
                    y_d  = sat8(pipe_sum);
                    d1_d = rdata_b;
                    d2_d = d1_q;
                    d3_d = d2_q;
                end
                if (n_q >= IW'(2)) begin
                    we_a      = 1'b1;
                    addr_a    = AW'(OUT_BASE) + n_q[AW-1:0] - 10'd2;
                    data_in_a = y_q;
                end
                if (n_q == IW'(N_SAMPLES + 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            n_q           <= '0;
            k_q           <= '0;
            pw_q          <= '0;
            acc_q         <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            d3_q          <= '0;
            y_q           <= '0;
            done_q        <= 1'b0;
            cycle_counter <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            n_q           <= n_d;
            k_q           <= k_d;
            pw_q          <= pw_d;
            acc_q         <= acc_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            d3_q          <= d3_d;
            y_q           <= y_d;
            done_q        <= done_d;
            cycle_counter <= cycle_counter_d;
        end
    end

    assign done        = done_q;
    assign cycle_count = cycle_counter[2:0];

    fir_dpram #(.DEPTH(MEM_DEPTH), .AW(AW)) memory (
        .clk       (clk),
        .addr_a    (addr_a),
        .we_a      (we_a),
        .data_in_a (data_in_a),
        .addr_b    (addr_b),
        .re_b      (re_b),
        .data_out_b(rdata_b)
    );
endmodule

// fir_dpram: 8-bit dual-port RAM, port A synchronous write, port B synchronous read
// Latency: port B data valid the cycle after re_b; contents are never reset
// Backpressure: none
module fir_dpram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic          we_a,
    input  logic [7:0]    data_in_a,
    input  logic [AW-1:0] addr_b,
    input  logic          re_b,
    output logic [7:0]    data_out_b
);
    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_in_a;
        if (re_b) data_out_b <= mem[addr_b];
    end
endmodule

// File: tb/tb_fir_filter_top.sv
module tb_fir_filter_top;
    localparam int OUT_BASE = 32;
    localparam int N        = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel_pipelined;
    logic       done;
    logic [2:0] cycle_count;

    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  wr_cnt = 0;
    byte img    [0:63];
    byte np_res [0:N-1];

    always #5 clk = ~clk;

    fir_filter_top dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sel_pipelined(sel_pipelined),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference filter straight from the definition, on the bench's own copy of the inputs
    function automatic int xi(input int k);
        return (k < 0) ? 0 : int'(img[k]);
    endfunction

    function automatic int model_y(input int n);
        int s;
        s = xi(n) + 2 * xi(n - 1) + 2 * xi(n - 2) + xi(n - 3);
        s = s >>> 3;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int out_at(input int i);
        return int'(byte'(dut.memory.mem[OUT_BASE + i]));
    endfunction

    // Every cycle: cycle_count mirrors the counter; every engine write lands in range with the model value
    always @(negedge clk) begin
        int a;
        check("cycle_count_low_bits", int'(cycle_count), int'(dut.cycle_counter[2:0]));
        if (dut.memory.we_a === 1'b1) begin
            a = int'(dut.memory.addr_a) - OUT_BASE;
            wr_cnt++;
            if (a < 0 || a >= N) check("write_addr_in_range", a, 0);
            else                 check("write_data", int'(byte'(dut.memory.data_in_a)), model_y(a));
        end
    end

    task automatic load_all(input int kind, input byte val);
        for (int i = 0; i < 64; i++) begin
            if (kind == 0) img[i] = byte'($rtoi(64.0 * $sin(2.0 * 3.14159265358979 * i / 40.0)));
            else           img[i] = val;
            dut.memory.mem[i] = img[i];
        end
    endtask

    task automatic poison_outputs();
        for (int i = 0; i < N; i++) dut.memory.mem[OUT_BASE + i] = 8'h55;
    endtask

    task automatic check_outputs(input string name);
        for (int i = 0; i < N; i++) check(name, out_at(i), model_y(i));
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_within_budget"}, int'(seen), 1);
    endtask

    // hold = cycles start stays high; 0 keeps it high past completion
    task automatic run(input logic pipe, input int hold, input string name);
        sel_pipelined = pipe;
        start         = 1'b1;
        wr_cnt        = 0;
        @(negedge clk);
        check({name, "_done_low_after_start"}, int'(done), 0);
        if (hold > 1) repeat (hold - 1) @(negedge clk);
        if (hold > 0) start = 1'b0;
        wait_done(name, 400);
        check({name, "_write_count"}, wr_cnt, N);
    endtask

    task automatic reset_mid_run(input logic pipe, input string name);
        poison_outputs();
        sel_pipelined = pipe;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({name, "_rst_done"}, int'(done), 0);
        check({name, "_rst_counter"}, int'(dut.cycle_counter), 0);
        check({name, "_rst_we_a"}, int'(dut.memory.we_a), 0);
        check({name, "_kept_output0"}, out_at(0), model_y(0));
        check({name, "_unwritten_output19"}, out_at(N - 1), 85);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(pipe, 1, {name, "_rerun"});
        check({name, "_rerun_counter"}, int'(dut.cycle_counter), pipe ? N + 2 : 6 * N);
        check_outputs({name, "_rerun_outputs"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        sel_pipelined = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_cycle_count", int'(cycle_count), 0);
        check("reset_counter", int'(dut.cycle_counter), 0);
        check("reset_we_a", int'(dut.memory.we_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Sine table; the first samples pin the bench's own table
        load_all(0, 0);
        check("load_mem0", int'(byte'(dut.memory.mem[0])), 0);
        check("load_mem1", int'(byte'(dut.memory.mem[1])), 10);
        check("load_mem2", int'(byte'(dut.memory.mem[2])), 19);
        check("load_mem3", int'(byte'(dut.memory.mem[3])), 29);

        // Non-pipelined, start held 10 cycles
        run(1'b0, 10, "np");
        check("np_counter", int'(dut.cycle_counter), 120);
        check("np_cycle_count", int'(cycle_count), 0);
        check("np_y0", out_at(0), 0);
        check("np_y1", out_at(1), 1);
        check("np_y2", out_at(2), 4);
        check("np_y3", out_at(3), 10);
        check_outputs("np_outputs");
        for (int i = 0; i < N; i++) np_res[i] = byte'(out_at(i));

        // Pipelined, start held through completion: must not restart
        run(1'b1, 0, "pp");
        check("pp_counter", int'(dut.cycle_counter), 22);
        check("pp_cycle_count", int'(cycle_count), 6);
        repeat (5) begin
            @(negedge clk);
            check("pp_done_held", int'(done), 1);
            check("pp_counter_frozen", int'(dut.cycle_counter), 22);
        end
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) check("pp_matches_np", out_at(i), int'(np_res[i]));

        // Positive saturation region
        load_all(1, 8'sd127);
        run(1'b0, 1, "np127");
        check("np127_y0", out_at(0), 15);
        check("np127_y1", out_at(1), 47);
        check("np127_y2", out_at(2), 79);
        check("np127_y3", out_at(3), 95);
        check_outputs("np127_outputs");
        poison_outputs();
        run(1'b1, 1, "pp127");
        check("pp127_y3", out_at(3), 95);
        check("pp127_counter", int'(dut.cycle_counter), 22);
        check_outputs("pp127_outputs");

        // Most negative input
        load_all(1, -8'sd128);
        run(1'b1, 1, "ppm128");
        check("ppm128_y3", out_at(3), -96);
        check_outputs("ppm128_outputs");
        run(1'b0, 1, "npm128");
        check("npm128_y3", out_at(3), -96);
        check("npm128_counter", int'(dut.cycle_counter), 120);

        // Reset in the middle of a run, both modes
        load_all(0, 0);
        reset_mid_run(1'b0, "np_rst");
        reset_mid_run(1'b1, "pp_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
